// File: rtl/sa_pkg.sv
// sa_pkg: shared types and helpers for the systolic-array row packer slice.
//   phase_t      : which tile the serial stream is currently filling.
//   row_entry_t  : one packed row plus its tags, as held in the row FIFO.
//   sa_cnt_w     : counter width for a count of n items (at least 1 bit).
//   sa_idx_w     : row-index width covering the larger of two row counts.
//   lane_lsb     : bit offset of a lane inside a packed row vector.
// The row-entry struct is sized for the widest supported configuration so it
// can live in the package; users fill and read only the low bits they need.
package sa_pkg;

  typedef enum logic {
    PH_W = 1'b0,
    PH_I = 1'b1
  } phase_t;

  localparam int SA_MAX_ROW_BITS = 2048;
  localparam int SA_MAX_IDX_W    = 16;

  typedef struct packed {
    logic [SA_MAX_ROW_BITS-1:0] data;
    logic                       is_weight;
    logic [SA_MAX_IDX_W-1:0]    idx;
    logic                       last;
  } row_entry_t;

  function automatic int sa_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sa_idx_w(input int a, input int b);
    return sa_cnt_w((a > b) ? a : b);
  endfunction

  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// sa_row_fifo: 2-entry FIFO of row_entry_t with a registered first word.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   push, push_entry : write a row (never issued when full)
//   pop              : consume the head row (ignored when empty)
//   head, head_valid : registered head entry and its valid
//   count            : occupancy 0..2
// Only the low COLS*DATA_W data bits and IDX_W index bits are stored; the
// rest of the package struct is returned as zero.
module sa_row_fifo
  import sa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COLS   = 32,
  parameter int IDX_W  = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  row_entry_t push_entry,
  input  logic       pop,
  output row_entry_t head,
  output logic       head_valid,
  output logic [1:0] count
);

  localparam int ROW_W = COLS * DATA_W;

  logic [ROW_W-1:0] head_data_p1, tail_data_p1;
  logic             head_w_p1, tail_w_p1;
  logic [IDX_W-1:0] head_idx_p1, tail_idx_p1;
  logic             head_last_p1, tail_last_p1;
  logic [1:0]       cnt_q;

  logic do_pop;
  logic head_from_push, head_from_tail, tail_load;
  logic unused_push;

  assign unused_push = ^push_entry;
  assign do_pop      = pop && (cnt_q != 2'd0);

  // Route the incoming row: it becomes the head when the FIFO is (or is about
  // to be) empty of older rows, otherwise it waits in the tail slot.
  always_comb begin
    head_from_push = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    unique case (cnt_q)
      2'd0: head_from_push = push;
      2'd1: begin
        head_from_push = push && do_pop;
        tail_load      = push && !do_pop;
      end
      default: begin
        head_from_tail = do_pop;
        tail_load      = push && do_pop;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else if (push && !do_pop) begin
      cnt_q <= cnt_q + 2'd1;
    end else if (!push && do_pop) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  // ---- stage p1: head row register (visible outputs, cleared by reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data_p1 <= '0;
      head_w_p1    <= 1'b0;
      head_idx_p1  <= '0;
      head_last_p1 <= 1'b0;
    end else if (head_from_push) begin
      head_data_p1 <= push_entry.data[ROW_W-1:0];
      head_w_p1    <= push_entry.is_weight;
      head_idx_p1  <= push_entry.idx[IDX_W-1:0];
      head_last_p1 <= push_entry.last;
    end else if (head_from_tail) begin
      head_data_p1 <= tail_data_p1;
      head_w_p1    <= tail_w_p1;
      head_idx_p1  <= tail_idx_p1;
      head_last_p1 <= tail_last_p1;
    end
  end

  // ---- stage p1: tail slot (only meaningful while count is 2) ----
  always_ff @(posedge clk) begin
    if (tail_load) begin
      tail_data_p1 <= push_entry.data[ROW_W-1:0];
      tail_w_p1    <= push_entry.is_weight;
      tail_idx_p1  <= push_entry.idx[IDX_W-1:0];
      tail_last_p1 <= push_entry.last;
    end
  end

  always_comb begin
    head                  = '0;
    head.data[ROW_W-1:0]  = head_data_p1;
    head.is_weight        = head_w_p1;
    head.idx[IDX_W-1:0]   = head_idx_p1;
    head.last             = head_last_p1;
  end

  assign head_valid = (cnt_q != 2'd0);
  assign count      = cnt_q;

endmodule

// File: rtl/sa_row_packer.sv
// sa_row_packer: packs the serial element stream (weight tile, then input
// tile) into full-width rows tagged with tile type and row index, buffered by
// a 2-entry row FIFO toward the systolic array.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : serial element handshake
//   in_last                      : end-of-tile marker (checked only with
//                                  LAST_CHECK_EN)
//   row_valid/row_ready          : row handshake
//   row_data                     : lane k at [k*DATA_W +: DATA_W]
//   row_is_weight, row_idx       : tags of the head row
//   row_last                     : head row is the final input row
//   tile_done                    : pulse the cycle after row_last is consumed
//   busy                         : partial row held or FIFO non-empty
//   err                          : sticky in_last protocol error
// Build option: define LAST_CHECK_EN to enable the in_last check; otherwise
// in_last is ignored and err is tied low.
module sa_row_packer
  import sa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int W_ROWS = 32,
  parameter int W_COLS = 32,
  parameter int I_ROWS = 512,
  parameter int I_COLS = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_data,
  input  logic                                in_last,
  output logic                                row_valid,
  input  logic                                row_ready,
  output logic [W_COLS*DATA_W-1:0]            row_data,
  output logic                                row_is_weight,
  output logic [sa_idx_w(W_ROWS, I_ROWS)-1:0] row_idx,
  output logic                                row_last,
  output logic                                tile_done,
  output logic                                busy,
  output logic                                err
);

  localparam int COLS  = W_COLS;
  localparam int ROW_W = COLS * DATA_W;
  localparam int IDX_W = sa_idx_w(W_ROWS, I_ROWS);
  localparam int CNT_W = sa_cnt_w(COLS);

  localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(COLS - 1);
  localparam logic [IDX_W-1:0] W_ROW_LAST = IDX_W'(W_ROWS - 1);
  localparam logic [IDX_W-1:0] I_ROW_LAST = IDX_W'(I_ROWS - 1);

  if (I_COLS != W_COLS) begin : g_cols_check
    $error("sa_row_packer: I_COLS (%0d) must equal W_COLS (%0d)", I_COLS, W_COLS);
  end
  if (ROW_W > SA_MAX_ROW_BITS || IDX_W > SA_MAX_IDX_W) begin : g_size_check
    $error("sa_row_packer: row or index width exceeds sa_pkg limits");
  end

  logic [CNT_W-1:0] col_cnt_q;
  logic [IDX_W-1:0] row_cnt_q;
  phase_t           phase_q;
  logic [ROW_W-1:0] asm_p0;

  logic             accept;
  logic             row_done;
  logic             phase_row_last;
  logic             final_input_row;
  logic [ROW_W-1:0] row_merged;
  row_entry_t       push_entry;
  row_entry_t       head;
  logic [1:0]       fifo_cnt;
  logic             tile_done_q;
  logic             unused_head;

  // A completing accept needs a free FIFO slot; partial-row accepts never do.
  // Only registered state feeds this, so row_ready has no path to in_ready.
  assign in_ready = (col_cnt_q != COL_LAST) || (fifo_cnt != 2'd2);
  assign accept   = in_valid && in_ready;
  assign row_done = accept && (col_cnt_q == COL_LAST);

  assign final_input_row = (phase_q == PH_I) && (row_cnt_q == I_ROW_LAST);
  assign phase_row_last  = (phase_q == PH_W) ? (row_cnt_q == W_ROW_LAST) : final_input_row;

  // ---- stage p0: element assembly ----
  always_ff @(posedge clk) begin
    if (accept) begin
      asm_p0[lane_lsb(int'(col_cnt_q), DATA_W) +: DATA_W] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      phase_q   <= PH_W;
    end else if (accept) begin
      if (col_cnt_q == COL_LAST) begin
        col_cnt_q <= '0;
        if (phase_row_last) begin
          row_cnt_q <= '0;
          phase_q   <= (phase_q == PH_W) ? PH_I : PH_W;
        end else begin
          row_cnt_q <= row_cnt_q + IDX_W'(1);
        end
      end else begin
        col_cnt_q <= col_cnt_q + CNT_W'(1);
      end
    end
  end

  // The final element is still on in_data when the row is pushed, so it is
  // merged into the top lane here rather than read back from asm_p0.
  always_comb begin
    row_merged = asm_p0;
    row_merged[lane_lsb(COLS - 1, DATA_W) +: DATA_W] = in_data;
  end

  always_comb begin
    push_entry                     = '0;
    push_entry.data[ROW_W-1:0]     = row_merged;
    push_entry.is_weight           = (phase_q == PH_W);
    push_entry.idx[IDX_W-1:0]      = row_cnt_q;
    push_entry.last                = final_input_row;
  end

  sa_row_fifo #(
    .DATA_W (DATA_W),
    .COLS   (COLS),
    .IDX_W  (IDX_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (row_done),
    .push_entry (push_entry),
    .pop        (row_ready),
    .head       (head),
    .head_valid (row_valid),
    .count      (fifo_cnt)
  );

  assign unused_head   = ^head;
  assign row_data      = head.data[ROW_W-1:0];
  assign row_is_weight = head.is_weight;
  assign row_idx       = head.idx[IDX_W-1:0];
  assign row_last      = head.last;

  // ---- stage p2: end-of-tile pulse ----
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= row_valid && row_ready && head.last;
    end
  end

  assign tile_done = tile_done_q;
  assign busy      = (col_cnt_q != '0) || (fifo_cnt != 2'd0);

`ifdef LAST_CHECK_EN
  logic err_q;
  logic final_pos;

  // in_last must be high exactly on the last element of the last input row.
  assign final_pos = final_input_row && (col_cnt_q == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && (in_last != final_pos)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_last;

  assign unused_last = in_last;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sa_row_packer.sv
`timescale 1ns/100ps
module tb_sa_row_packer;

  localparam int DATA_W     = 16;
  localparam int W_ROWS     = 2;
  localparam int COLS       = 4;
  localparam int I_ROWS     = 3;
  localparam int ROW_W      = COLS * DATA_W;
  localparam int IDX_W      = 2;
  localparam int TILE_ROWS  = W_ROWS + I_ROWS;
  localparam int TILE_ELEMS = TILE_ROWS * COLS;

`ifdef LAST_CHECK_EN
  localparam bit ERR_EXPECT = 1'b1;
`else
  localparam bit ERR_EXPECT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              row_valid;
  logic              row_ready;
  logic [ROW_W-1:0]  row_data;
  logic              row_is_weight;
  logic [IDX_W-1:0]  row_idx;
  logic              row_last;
  logic              tile_done;
  logic              busy;
  logic              err;

  sa_row_packer #(
    .DATA_W (DATA_W),
    .W_ROWS (W_ROWS),
    .W_COLS (COLS),
    .I_ROWS (I_ROWS),
    .I_COLS (COLS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_data      (row_data),
    .row_is_weight (row_is_weight),
    .row_idx       (row_idx),
    .row_last      (row_last),
    .tile_done     (tile_done),
    .busy          (busy),
    .err           (err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [ROW_W-1:0] data;
    bit               is_w;
    int               idx;
    bit               last;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] cur_row[$];
  int                acc_cnt;
  int                drv_pos;
  int                n_tests = 0;
  int                n_fail  = 0;
  int                n_rows;
  int                td_pulses;
  bit                td_pend;
  bit                rr_rand;
  logic [ROW_W-1:0]  got_data[64];
  bit                got_w[64];
  int                got_idx[64];
  bit                got_last[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  // Reference model, input side: every COLS accepted elements form a row whose
  // tags follow from its position inside the repeating tile of TILE_ROWS rows.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      int   pos;
      int   r;
      pos = acc_cnt % TILE_ELEMS;
      acc_cnt++;
      cur_row.push_back(in_data);
      if (cur_row.size() == COLS) begin
        r      = pos / COLS;
        e.data = '0;
        for (int k = 0; k < COLS; k++) e.data[k*DATA_W +: DATA_W] = cur_row[k];
        e.is_w = (r < W_ROWS);
        e.idx  = e.is_w ? r : r - W_ROWS;
        e.last = (r == TILE_ROWS - 1);
        exp_q.push_back(e);
        cur_row.delete();
      end
    end
  end

  // Output monitor: compares every consumed row against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      td_pend = 1'b0;
    end else begin
      check("tile_done", 64'(tile_done), 64'(td_pend));
      if (tile_done) td_pulses++;
      td_pend = 1'b0;
      if (row_valid && row_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_row: actual data 0x%0h, required no row", row_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("row_data", 64'(row_data), 64'(e.data));
          check("row_is_weight", 64'(row_is_weight), 64'(e.is_w));
          check("row_idx", 64'(row_idx), 64'(e.idx));
          check("row_last", 64'(row_last), 64'(e.last));
          td_pend = e.last;
          if (n_rows < 64) begin
            got_data[n_rows] = row_data;
            got_w[n_rows]    = row_is_weight;
            got_idx[n_rows]  = int'(row_idx);
            got_last[n_rows] = row_last;
          end
          n_rows++;
        end
      end
    end
  end

  // Mid-cycle status checks: readiness, visibility and busy follow from how
  // many rows are waiting and how full the current row is.
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      check("in_ready", 64'(in_ready),
            64'((cur_row.size() != COLS - 1) || (exp_q.size() != 2)));
      check("row_valid", 64'(row_valid), 64'(exp_q.size() != 0));
      check("busy", 64'(busy), 64'((cur_row.size() != 0) || (exp_q.size() != 0)));
    end
  end

  always @(posedge clk) begin
    #1;
    if (rr_rand) row_ready = 1'($urandom_range(0, 1));
  end

  task automatic wait_accept();
    int budget;
    budget = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: actual in_ready 0, required 1 within 300 cycles");
        summary();
        $fatal(1, "input stalled");
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drv_pos++;
  endtask

  // Called at posedge+1; returns at posedge+1 after the element is accepted.
  task automatic send_elem(input logic [DATA_W-1:0] v, input bit last, input bit gappy);
    if (gappy) begin
      while ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    wait_accept();
  endtask

  function automatic bit nat_last();
    return (drv_pos % TILE_ELEMS) == TILE_ELEMS - 1;
  endfunction

  task automatic send_n(input int start, input int n, input bit gappy);
    for (int i = 0; i < n; i++) send_elem(DATA_W'(start + i), nat_last(), gappy);
  endtask

  task automatic clear_log();
    n_rows    = 0;
    td_pulses = 0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #2;
    exp_q.delete();
    cur_row.delete();
    acc_cnt = 0;
    drv_pos = 0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_row_valid", 64'(row_valid), 64'd0);
    check("rst_row_data", 64'(row_data), 64'd0);
    check("rst_row_is_weight", 64'(row_is_weight), 64'd0);
    check("rst_row_idx", 64'(row_idx), 64'd0);
    check("rst_row_last", 64'(row_last), 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: actual %0d rows pending, required 0", exp_q.size());
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    row_ready = 1'b1;
    rr_rand   = 1'b0;
    acc_cnt   = 0;
    drv_pos   = 0;
    td_pend   = 1'b0;
    clear_log();
    @(posedge clk);
    #1;
    do_reset();

    // One tile, consumer always ready.
    clear_log();
    send_n(1, 20, 1'b0);
    drain();
    check("t1_rows", 64'(n_rows), 64'd5);
    check("t1_tile_done_pulses", 64'(td_pulses), 64'd1);
    check("t1_row0_data", 64'(got_data[0]), 64'h0004_0003_0002_0001);
    check("t1_row0_is_weight", 64'(got_w[0]), 64'd1);
    check("t1_row0_idx", 64'(got_idx[0]), 64'd0);
    check("t1_row2_data", 64'(got_data[2]), 64'h000C_000B_000A_0009);
    check("t1_row2_is_weight", 64'(got_w[2]), 64'd0);
    check("t1_row2_idx", 64'(got_idx[2]), 64'd0);
    check("t1_row4_idx", 64'(got_idx[4]), 64'd2);
    check("t1_row4_last", 64'(got_last[4]), 64'd1);

    // Consumer stalled: two rows buffer, third row's final element waits.
    clear_log();
    row_ready = 1'b0;
    send_n(1, 11, 1'b0);
    in_valid = 1'b1;
    in_data  = DATA_W'(12);
    in_last  = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t3_stall_in_ready", 64'(in_ready), 64'd0);
    check("t3_rows_held", 64'(row_valid), 64'd1);
    #4;
    row_ready = 1'b1;
    #1;
    check("t3_ready_not_comb", 64'(in_ready), 64'd0);
    wait_accept();
    send_n(13, 8, 1'b0);
    drain();
    check("t3_rows", 64'(n_rows), 64'd5);

    // Two back-to-back tiles.
    do_reset();
    clear_log();
    send_n(1, 40, 1'b0);
    drain();
    check("t4_rows", 64'(n_rows), 64'd10);
    check("t4_row5_data", 64'(got_data[5]), 64'h0018_0017_0016_0015);
    check("t4_row5_is_weight", 64'(got_w[5]), 64'd1);
    check("t4_row5_idx", 64'(got_idx[5]), 64'd0);
    check("t4_tile_done_pulses", 64'(td_pulses), 64'd2);

    // Reset in the middle of a tile.
    do_reset();
    send_n(1, 6, 1'b0);
    do_reset();
    clear_log();
    send_elem(16'hAAAA, nat_last(), 1'b0);
    send_n(16'h0100, 19, 1'b0);
    drain();
    check("t5_rows", 64'(n_rows), 64'd5);
    check("t5_row0_lane0", 64'(got_data[0][DATA_W-1:0]), 64'hAAAA);
    check("t5_row0_is_weight", 64'(got_w[0]), 64'd1);
    check("t5_row0_idx", 64'(got_idx[0]), 64'd0);
    check("t5_err_clean", 64'(err), 64'd0);

    // Early in_last on element 19 of a tile.
    clear_log();
    for (int i = 0; i < 20; i++) send_elem(DATA_W'(16'h0200 + i), nat_last() || (i == 18), 1'b0);
    drain();
    check("t6_err_set", 64'(err), 64'(ERR_EXPECT));
    send_n(16'h0300, 4, 1'b0);
    drain();
    check("t6_err_sticky", 64'(err), 64'(ERR_EXPECT));
    do_reset();

    // Random handshakes on both sides, three tiles of random data.
    clear_log();
    rr_rand = 1'b1;
    for (int i = 0; i < 3 * TILE_ELEMS; i++) send_elem(DATA_W'($urandom), nat_last(), 1'b1);
    rr_rand   = 1'b0;
    row_ready = 1'b1;
    drain();
    check("t7_rows", 64'(n_rows), 64'd15);
    check("t7_tile_done_pulses", 64'(td_pulses), 64'd3);
    check("t7_err", 64'(err), 64'd0);

    summary();
    $finish;
  end

  initial begin
    #400000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: actual simulation still running, required completion");
    summary();
    $fatal(1, "watchdog expired");
  end

endmodule
